// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, synchronises and
// debounces the rows, and emits a one-cycle key_valid strobe with a 4-bit key code.
module keypad_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_SCAN    = 2'd0,
        S_DEB     = 2'd1,
        S_PRESSED = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [3:0]      row_m, row_s, row_lat;
    logic [TW-1:0]   timer;
    logic [1:0]      col;
    logic [CW-1:0]   cnt, cnt_inc;
    logic            sample, row_idle, one_low, cnt_done;
    logic            adv_col, load_key, accept, released, cnt_one, cnt_step;
    logic [3:0]      src_row;

    function automatic logic [1:0] row_idx(input logic [3:0] p);
        case (p)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            default: row_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: map_key = 4'h1;
            4'b00_01: map_key = 4'h2;
            4'b00_10: map_key = 4'h3;
            4'b00_11: map_key = 4'hA;
            4'b01_00: map_key = 4'h4;
            4'b01_01: map_key = 4'h5;
            4'b01_10: map_key = 4'h6;
            4'b01_11: map_key = 4'hB;
            4'b10_00: map_key = 4'h7;
            4'b10_01: map_key = 4'h8;
            4'b10_10: map_key = 4'h9;
            4'b10_11: map_key = 4'hC;
            4'b11_00: map_key = 4'hF;
            4'b11_01: map_key = 4'h0;
            4'b11_10: map_key = 4'hE;
            default:  map_key = 4'hD;
        endcase
    endfunction

    assign sample   = (timer == T_LAST);
    assign row_idle = &row_s;
    assign one_low  = (row_s == 4'b1110) || (row_s == 4'b1101) ||
                      (row_s == 4'b1011) || (row_s == 4'b0111);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign cnt_done = (cnt_inc == CNT_MAX);
    // With DEBOUNCE=1 the key is accepted in the same cycle the row is latched.
    assign src_row  = load_key ? row_s : row_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_SCAN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        adv_col    = 1'b0;
        load_key   = 1'b0;
        accept     = 1'b0;
        released   = 1'b0;
        cnt_one    = 1'b0;
        cnt_step   = 1'b0;
        case (state)
            S_SCAN: if (sample) begin
                if (one_low) begin
                    load_key = 1'b1;
                    cnt_one  = 1'b1;
                    if (DEBOUNCE == 1) begin
                        state_next = S_PRESSED;
                        accept     = 1'b1;
                    end else begin
                        state_next = S_DEB;
                    end
                end else begin
                    adv_col = 1'b1;
                end
            end
            S_DEB: if (sample) begin
                if (row_s == row_lat) begin
                    cnt_step = 1'b1;
                    if (cnt_done) begin
                        state_next = S_PRESSED;
                        accept     = 1'b1;
                    end
                end else begin
                    state_next = S_SCAN;
                    adv_col    = 1'b1;
                end
            end
            S_PRESSED: if (sample && row_idle) begin
                if (DEBOUNCE == 1) begin
                    state_next = S_SCAN;
                    released   = 1'b1;
                    adv_col    = 1'b1;
                end else begin
                    state_next = S_RELEASE;
                    cnt_one    = 1'b1;
                end
            end
            S_RELEASE: if (sample) begin
                if (row_idle) begin
                    cnt_step = 1'b1;
                    if (cnt_done) begin
                        state_next = S_SCAN;
                        released   = 1'b1;
                        adv_col    = 1'b1;
                    end
                end else begin
                    state_next = S_PRESSED;
                end
            end
            default: state_next = S_SCAN;
        endcase
    end

    // key_valid is a bare strobe: no ready/backpressure, consumers must capture it in that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m     <= 4'b1111;
            row_s     <= 4'b1111;
            row_lat   <= 4'b1111;
            timer     <= '0;
            col       <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_m     <= row_in;
            row_s     <= row_m;
            timer     <= sample ? '0 : timer + 1'b1;
            key_valid <= accept;
            if (adv_col)  col     <= col + 2'd1;
            if (load_key) row_lat <= row_s;
            if (cnt_one)       cnt <= CW'(1);
            else if (cnt_step) cnt <= cnt_inc;
            if (accept) begin
                key_code <= map_key(row_idx(src_row), col);
                key_held <= 1'b1;
            end else if (released) begin
                key_held <= 1'b0;
            end
        end
    end

    always_comb begin
        col_out = ~(4'b0001 << col);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the rows from the column drive and a
// press mask; every expected key code is queued at press time and popped on key_valid.
module tb_keypad_scanner;

    localparam int SD  = 16;
    localparam int DB  = 4;
    localparam int LAT = 4*SD + DB*SD + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, key_held;
    logic [15:0] press_mask;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;

    vec_t       vecs[7];
    logic [3:0] col_seq[4];
    logic [3:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         strobe_cnt = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            logic [3:0] e;
            strobe_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: key_code=%h but no strobe expected", key_code);
            end else begin
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    fails++;
                    $display("FAIL strobe_code: key_code=%h expected %h", key_code, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe(input int target, input string name, output int used);
        used = 0;
        while (strobe_cnt < target && used < LAT) begin
            @(negedge clk);
            used++;
        end
        check(name, strobe_cnt, target);
    endtask

    task automatic press_key(input int r, input int c, input logic [3:0] code, input string name);
        int used;
        int target;
        target = strobe_cnt + 1;
        exp_q.push_back(code);
        press_mask[r*4+c] = 1'b1;
        wait_strobe(target, {name, "_strobe"}, used);
        check({name, "_held"}, key_held, 1'b1);
        wait_cycles(200 - used);
        check({name, "_no_repeat"}, strobe_cnt, target);
        press_mask = '0;
        wait_cycles(100);
        check({name, "_released"}, key_held, 1'b0);
        check({name, "_code_kept"}, key_code, code);
    endtask

    initial begin
        int used;
        int target;
        int base;
        int n;
        logic [3:0] c0;

        vecs[0] = '{1, 1, 4'h5};
        vecs[1] = '{0, 0, 4'h1};
        vecs[2] = '{0, 3, 4'hA};
        vecs[3] = '{3, 1, 4'h0};
        vecs[4] = '{2, 2, 4'h9};
        vecs[5] = '{3, 3, 4'hD};
        vecs[6] = '{1, 3, 4'hB};
        col_seq[0] = 4'b1101;
        col_seq[1] = 4'b1011;
        col_seq[2] = 4'b0111;
        col_seq[3] = 4'b1110;

        // Reset and idle scanning.
        rst_n      = 1'b0;
        press_mask = '0;
        wait_cycles(3);
        check("reset_col", col_out, 4'b1110);
        check("reset_valid", key_valid, 1'b0);
        check("reset_held", key_held, 1'b0);
        check("reset_code", key_code, 4'h0);
        rst_n = 1'b1;

        n = 0;
        while (col_out == 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("col_first_step", col_out, col_seq[0]);
        for (int k = 1; k < 4; k++) begin
            wait_cycles(15);
            check("col_hold", col_out, col_seq[k-1]);
            wait_cycles(1);
            check("col_step", col_out, col_seq[k]);
        end
        check("idle_no_strobe", strobe_cnt, 0);

        // Single presses from the vector table.
        for (int i = 0; i < 7; i++)
            press_key(vecs[i].r, vecs[i].c, vecs[i].code, $sformatf("key%0d", i));

        // "#" with three bounces, then settled.
        base   = strobe_cnt;
        target = base + 1;
        exp_q.push_back(4'hE);
        for (int i = 0; i < 6; i++) begin
            press_mask[14] = (i % 2 == 0);
            wait_cycles(8);
        end
        check("bounce_no_strobe", strobe_cnt, base);
        press_mask[14] = 1'b1;
        wait_strobe(target, "bounce_strobe", used);
        check("bounce_code", key_code, 4'hE);
        wait_cycles(150);
        check("bounce_single", strobe_cnt, target);
        press_mask = '0;
        wait_cycles(100);
        check("bounce_released", key_held, 1'b0);

        // A and C together in column 3: ghost, no accept.
        base = strobe_cnt;
        press_mask[3]  = 1'b1;
        press_mask[11] = 1'b1;
        wait_cycles(200);
        check("ghost_no_strobe", strobe_cnt, base);
        check("ghost_not_held", key_held, 1'b0);
        c0 = col_out;
        n  = 0;
        while (col_out == c0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ghost_scanning", (col_out != c0), 1'b1);
        exp_q.push_back(4'hA);
        press_mask[11] = 1'b0;
        wait_strobe(base + 1, "ghost_a_strobe", used);
        check("ghost_a_code", key_code, 4'hA);
        wait_cycles(50);
        press_mask = '0;
        wait_cycles(100);
        check("ghost_released", key_held, 1'b0);

        // Hold C, press 1 on top: only C is reported.
        target = strobe_cnt + 1;
        exp_q.push_back(4'hC);
        press_mask[11] = 1'b1;
        wait_strobe(target, "hold_c_strobe", used);
        press_mask[0] = 1'b1;
        wait_cycles(200);
        check("hold_c_ignore_1", strobe_cnt, target);
        check("hold_c_held", key_held, 1'b1);
        check("hold_c_code", key_code, 4'hC);
        press_mask = '0;
        wait_cycles(100);
        check("hold_c_released", key_held, 1'b0);
        press_key(0, 0, 4'h1, "key1_after_c");

        // Reset while "*" is held.
        target = strobe_cnt + 1;
        exp_q.push_back(4'hF);
        press_mask[12] = 1'b1;
        wait_strobe(target, "star_strobe", used);
        wait_cycles(30);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_col", col_out, 4'b1110);
            check("rst_mid_valid", key_valid, 1'b0);
            check("rst_mid_held", key_held, 1'b0);
        end
        rst_n  = 1'b1;
        target = strobe_cnt + 1;
        exp_q.push_back(4'hF);
        wait_strobe(target, "star_reaccept", used);
        check("star_code", key_code, 4'hF);
        wait_cycles(150);
        check("star_single", strobe_cnt, target);
        press_mask = '0;
        wait_cycles(100);
        check("star_released", key_held, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
